pipe_scroller: RTL and testbench

- Upstream producer of the `pipe_pos`, `pipe_array0`, `pipe_array1` and `current_score` inputs consumed by the VGA 640x480 renderer.
- Advances the pipe scroll offset once per video frame, recycles pipes at the scroll span, draws new gap heights from a free-running LFSR, and counts pipes cleared by the bird.
- Run state is controlled by `start` and by `crash` from the collision logic. Sits in the 25 MHz pixel-clock domain.

---
 rtl/pipe_scroller_if.sv | 32 +++
 rtl/pipe_scroller.sv | 173 +++++++++++++++++
 tb/tb_pipe_scroller.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_scroller_if.sv
// pipe_scroller_if
// Bundles the frame/run controls into the scroller and the scroll/score
// results going out to the VGA renderer.
//   vsync         : active-low vsync from the renderer; a falling edge marks a frame
//   start, crash  : run control levels (start/restart, collision detected)
//   pipe_pos      : scroll offset, 0..SPAN-1
//   pipe_array0/1 : gap tops of the near and far pipes
//   current_score : pipes cleared, saturating
//   score_pulse   : one-clock strobe on each score increment
//   running       : high while the game is running
// modport master : the scroller itself. modport slave : the renderer/environment.
interface pipe_scroller_if;
    logic       vsync;
    logic       start;
    logic       crash;
    logic [8:0] pipe_pos;
    logic [7:0] pipe_array0;
    logic [7:0] pipe_array1;
    logic [3:0] current_score;
    logic       score_pulse;
    logic       running;

    modport master (
        input  vsync, start, crash,
        output pipe_pos, pipe_array0, pipe_array1, current_score, score_pulse, running
    );

    modport slave (
        output vsync, start, crash,
        input  pipe_pos, pipe_array0, pipe_array1, current_score, score_pulse, running
    );
endinterface

// File: rtl/pipe_scroller.sv
// pipe_scroller
// Scrolls the pipe field once per video frame, recycles pipes when the scroll
// offset spans one pipe spacing, draws new gap heights from a free-running
// LFSR and counts pipes cleared by the bird. Runs in the 25 MHz pixel clock.
//   dclk : pixel clock
//   clr  : asynchronous active-high reset
//   bus  : pipe_scroller_if.master (vsync/start/crash in, scroll/score out)
module pipe_scroller #(
    parameter int unsigned SPAN      = 345,
    parameter int unsigned SPEED     = 2,
    parameter int unsigned PASS_POS  = 256,
    parameter int unsigned GAP_MAX   = 200,
    parameter int unsigned SCORE_MAX = 15,
    parameter logic [7:0]  SEED      = 8'hA5
) (
    input  logic            dclk,
    input  logic            clr,
    pipe_scroller_if.master bus
);
    localparam logic [9:0] SPAN_W   = 10'(SPAN);
    localparam logic [9:0] SPEED_W  = 10'(SPEED);
    localparam logic [9:0] PASS_W   = 10'(PASS_POS);
    localparam logic [7:0] GAP_W    = 8'(GAP_MAX);
    localparam logic [3:0] SCORE_W  = 4'(SCORE_MAX);
    localparam logic [8:0] POS_RST  = 9'd0;
    localparam logic [7:0] ARR0_RST = 8'd100;
    localparam logic [7:0] ARR1_RST = 8'd60;
    localparam logic [3:0] SCR_RST  = 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    // Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1 (maximal length, so a
    // nonzero seed can never reach the all-zero lockup state).
    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    // Folds the 0..255 LFSR value into the legal gap range 0..GAP_MAX.
    function automatic logic [7:0] gap_of(input logic [7:0] v);
        return (v > GAP_W) ? (v - GAP_W) : v;
    endfunction

    state_t     state_r, state_s;
    logic [7:0] lfsr_r;
    logic       vsync_d_r;
    logic       tick_r;
    logic [9:0] sum_s;
    logic [8:0] pos_r, pos_s;
    logic [7:0] arr0_r, arr0_s;
    logic [7:0] arr1_r, arr1_s;
    logic [3:0] score_r, score_s;
    logic       pulse_r, pulse_s;
    logic       running_r, running_s;

    // Frame tick: registered falling-edge detect of vsync, plus the free-running LFSR.
    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            vsync_d_r <= 1'b1;
            tick_r    <= 1'b0;
            lfsr_r    <= SEED;
        end else begin
            vsync_d_r <= bus.vsync;
            tick_r    <= vsync_d_r & ~bus.vsync;
            lfsr_r    <= lfsr_step(lfsr_r);
        end
    end

    // FSM state register.
    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state and next output values; IDLE forces reset values, HALT freezes.
    always_comb begin
        state_s = state_r;
        pos_s   = pos_r;
        arr0_s  = arr0_r;
        arr1_s  = arr1_r;
        score_s = score_r;
        pulse_s = 1'b0;
        sum_s   = {1'b0, pos_r} + SPEED_W;
        case (state_r)
            IDLE: begin
                pos_s   = POS_RST;
                arr0_s  = ARR0_RST;
                arr1_s  = ARR1_RST;
                score_s = SCR_RST;
                if (bus.start) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                // crash wins over a same-cycle tick: no advance on the crash clock
                if (bus.crash) begin
                    state_s = HALT;
                end else if (tick_r) begin
                    state_s = RUN;
                    if (sum_s >= SPAN_W) begin
                        // far pipe slides into the near slot at the same screen x
                        pos_s  = 9'(sum_s - SPAN_W);
                        arr0_s = arr1_r;
                        arr1_s = gap_of(lfsr_r);
                    end else begin
                        pos_s = sum_s[8:0];
                        if (({1'b0, pos_r} < PASS_W) && (sum_s >= PASS_W)) begin
                            score_s = (score_r >= SCORE_W) ? SCORE_W : (score_r + 4'd1);
                            pulse_s = 1'b1;
                        end else begin
                            score_s = score_r;
                        end
                    end
                end else begin
                    state_s = RUN;
                end
            end
            HALT: begin
                if (bus.start) begin
                    state_s = IDLE;
                    pos_s   = POS_RST;
                    arr0_s  = ARR0_RST;
                    arr1_s  = ARR1_RST;
                    score_s = SCR_RST;
                end else begin
                    state_s = HALT;
                end
            end
            default: begin
                state_s = IDLE;
                pos_s   = POS_RST;
                arr0_s  = ARR0_RST;
                arr1_s  = ARR1_RST;
                score_s = SCR_RST;
            end
        endcase
        running_s = (state_s == RUN);
    end

    // Registered outputs.
    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            pos_r     <= POS_RST;
            arr0_r    <= ARR0_RST;
            arr1_r    <= ARR1_RST;
            score_r   <= SCR_RST;
            pulse_r   <= 1'b0;
            running_r <= 1'b0;
        end else begin
            pos_r     <= pos_s;
            arr0_r    <= arr0_s;
            arr1_r    <= arr1_s;
            score_r   <= score_s;
            pulse_r   <= pulse_s;
            running_r <= running_s;
        end
    end

    assign bus.pipe_pos      = pos_r;
    assign bus.pipe_array0   = arr0_r;
    assign bus.pipe_array1   = arr1_r;
    assign bus.current_score = score_r;
    assign bus.score_pulse   = pulse_r;
    assign bus.running       = running_r;
endmodule

// File: tb/tb_pipe_scroller.sv
// tb_pipe_scroller
// Self-checking bench for pipe_scroller: a table of scripted run steps with
// constant expectations, hand sequences for latency, crash/halt, saturation
// and asynchronous reset, then random stimulus, all shadowed by a frame-level
// reference model compared on every falling clock edge.
module tb_pipe_scroller;
    localparam int SPAN   = 345;
    localparam int SPEED  = 2;
    localparam int PASS   = 256;
    localparam int GAPMAX = 200;
    localparam int SMAX   = 15;

    logic dclk = 1'b0;
    logic clr  = 1'b0;

    pipe_scroller_if sb ();

    pipe_scroller dut (
        .dclk (dclk),
        .clr  (clr),
        .bus  (sb)
    );

    always #5 dclk = ~dclk;

    int n_vec     = 0;
    int n_bad     = 0;
    bit chk_en    = 1'b0;
    int pulse_cnt = 0;

    task automatic check(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // mode: 0 = idle, 1 = running, 2 = halted
    int         m_mode;
    int         m_pos, m_a0, m_a1, m_score;
    bit         m_pulse, m_prev_vs, m_tick, t_now;
    logic [7:0] m_lfsr;

    always @(posedge dclk or posedge clr) begin
        if (clr) begin
            m_mode = 0; m_pos = 0; m_a0 = 100; m_a1 = 60; m_score = 0;
            m_pulse = 1'b0; m_prev_vs = 1'b1; m_tick = 1'b0; m_lfsr = 8'hA5;
        end else begin
            // a vsync fall seen at this edge is acted on one edge later
            t_now     = m_tick;
            m_tick    = m_prev_vs && !sb.vsync;
            m_prev_vs = sb.vsync;
            m_pulse   = 1'b0;
            if (m_mode == 0) begin
                if (sb.start) m_mode = 1;
            end else if (m_mode == 1) begin
                if (sb.crash) begin
                    m_mode = 2;
                end else if (t_now) begin
                    if (m_pos + SPEED >= SPAN) begin
                        m_pos = m_pos + SPEED - SPAN;
                        m_a0  = m_a1;
                        m_a1  = (int'(m_lfsr) > GAPMAX) ? int'(m_lfsr) - GAPMAX : int'(m_lfsr);
                    end else begin
                        if (m_pos < PASS && m_pos + SPEED >= PASS) begin
                            m_score = (m_score + 1 > SMAX) ? SMAX : m_score + 1;
                            m_pulse = 1'b1;
                        end
                        m_pos = m_pos + SPEED;
                    end
                end
            end else begin
                if (sb.start) begin
                    m_mode = 0; m_pos = 0; m_a0 = 100; m_a1 = 60; m_score = 0;
                end
            end
            m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
        end
    end

    // continuous comparison against the model, away from the active edge
    always @(negedge dclk) begin
        if (chk_en) begin
            check("pipe_pos",      int'(sb.pipe_pos),      m_pos);
            check("pipe_array0",   int'(sb.pipe_array0),   m_a0);
            check("pipe_array1",   int'(sb.pipe_array1),   m_a1);
            check("current_score", int'(sb.current_score), m_score);
            check("score_pulse",   int'(sb.score_pulse),   int'(m_pulse));
            check("running",       int'(sb.running),       (m_mode == 1) ? 1 : 0);
            check("pos_below_span", int'(sb.pipe_pos < 9'd345), 1);
            check("gap_in_range",  int'(sb.pipe_array1 <= 8'd200), 1);
            check("lfsr",          int'(dut.lfsr_r),       int'(m_lfsr));
            if (sb.score_pulse) pulse_cnt++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge dclk) sb.vsync = 1'b0;
            @(negedge dclk) sb.vsync = 1'b1;
            @(negedge dclk);
        end
    endtask

    task automatic pulse_start();
        @(negedge dclk) sb.start = 1'b1;
        @(negedge dclk) sb.start = 1'b0;
    endtask

    task automatic pulse_crash();
        @(negedge dclk) sb.crash = 1'b1;
        @(negedge dclk) sb.crash = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_pos"},   int'(sb.pipe_pos),      0);
        check({tag, "_a0"},    int'(sb.pipe_array0),   100);
        check({tag, "_a1"},    int'(sb.pipe_array1),   60);
        check({tag, "_score"}, int'(sb.current_score), 0);
        check({tag, "_pulse"}, int'(sb.score_pulse),   0);
        check({tag, "_run"},   int'(sb.running),       0);
    endtask

    typedef struct {
        bit st;
        bit cr;
        int nfr;
        int pos;
        int score;
        int run;
        int a0;
    } vec_t;

    vec_t tbl[10];

    initial begin
        tbl[0] = '{st: 1'b0, cr: 1'b0, nfr: 10,  pos: 0,   score: 0, run: 0, a0: 100};
        tbl[1] = '{st: 1'b1, cr: 1'b0, nfr: 5,   pos: 10,  score: 0, run: 1, a0: 100};
        tbl[2] = '{st: 1'b0, cr: 1'b0, nfr: 122, pos: 254, score: 0, run: 1, a0: 100};
        tbl[3] = '{st: 1'b0, cr: 1'b0, nfr: 1,   pos: 256, score: 1, run: 1, a0: 100};
        tbl[4] = '{st: 1'b0, cr: 1'b0, nfr: 44,  pos: 344, score: 1, run: 1, a0: 100};
        tbl[5] = '{st: 1'b0, cr: 1'b0, nfr: 1,   pos: 1,   score: 1, run: 1, a0: 60};
        tbl[6] = '{st: 1'b0, cr: 1'b0, nfr: 50,  pos: 101, score: 1, run: 1, a0: 60};
        tbl[7] = '{st: 1'b0, cr: 1'b1, nfr: 3,   pos: 101, score: 1, run: 0, a0: 60};
        tbl[8] = '{st: 1'b1, cr: 1'b0, nfr: 3,   pos: 0,   score: 0, run: 0, a0: 100};
        tbl[9] = '{st: 1'b1, cr: 1'b0, nfr: 4,   pos: 8,   score: 0, run: 1, a0: 100};

        sb.vsync = 1'b1;
        sb.start = 1'b0;
        sb.crash = 1'b0;
        #1 clr = 1'b1;
        #1 check_reset_vals("por");
        repeat (2) @(negedge dclk);
        clr    = 1'b0;
        chk_en = 1'b1;

        // scripted steps with constant expectations
        for (int r = 0; r < 10; r++) begin
            if (tbl[r].st) pulse_start();
            if (tbl[r].cr) pulse_crash();
            frames(tbl[r].nfr);
            repeat (2) @(negedge dclk);
            check($sformatf("tbl%0d_pos", r),   int'(sb.pipe_pos),      tbl[r].pos);
            check($sformatf("tbl%0d_score", r), int'(sb.current_score), tbl[r].score);
            check($sformatf("tbl%0d_run", r),   int'(sb.running),       tbl[r].run);
            check($sformatf("tbl%0d_a0", r),    int'(sb.pipe_array0),   tbl[r].a0);
        end

        // two-clock latency from vsync fall to pipe_pos update (pos is 8 here)
        @(negedge dclk) sb.vsync = 1'b0;
        @(negedge dclk) sb.vsync = 1'b1;
        check("lat_1clk", int'(sb.pipe_pos), 8);
        @(negedge dclk);
        check("lat_2clk", int'(sb.pipe_pos), 10);
        @(negedge dclk);
        check("lat_3clk", int'(sb.pipe_pos), 10);

        // crash on the very clock the tick is acted on, at pipe_pos 100
        frames(45);
        check("pre_crash_pos", int'(sb.pipe_pos), 100);
        @(negedge dclk) sb.vsync = 1'b0;
        @(negedge dclk) begin sb.vsync = 1'b1; sb.crash = 1'b1; end
        @(negedge dclk) sb.crash = 1'b0;
        check("crash_pos", int'(sb.pipe_pos), 100);
        check("crash_run", int'(sb.running),  0);
        frames(3);
        check("halt_pos", int'(sb.pipe_pos), 100);
        pulse_start();
        @(negedge dclk);
        check_reset_vals("idle_again");
        pulse_start();
        @(negedge dclk);
        check("rerun", int'(sb.running), 1);

        // 20 crossings of the pass point: saturates at 15, one pulse per crossing
        pulse_cnt = 0;
        frames(3500);
        repeat (2) @(negedge dclk);
        check("sat_pos",    int'(sb.pipe_pos),      100);
        check("sat_score",  int'(sb.current_score), 15);
        check("sat_pulses", pulse_cnt,              20);

        // asynchronous reset mid-run with a nonzero score
        pulse_crash();
        pulse_start();
        pulse_start();
        frames(1307);
        repeat (2) @(negedge dclk);
        check("mid_pos",   int'(sb.pipe_pos),      199);
        check("mid_score", int'(sb.current_score), 7);
        #2 clr = 1'b1;
        #1 check_reset_vals("async_clr");
        @(negedge dclk) clr = 1'b0;

        // LFSR sweep: never zero (model comparison runs alongside)
        for (int i = 0; i < 256; i++) begin
            @(negedge dclk);
            check("lfsr_nonzero", int'(dut.lfsr_r != 8'd0), 1);
        end

        // random stimulus against the model
        for (int i = 0; i < 4000; i++) begin
            @(negedge dclk);
            sb.vsync = ($urandom_range(0, 2) != 0);
            sb.start = ($urandom_range(0, 40) == 0);
            sb.crash = ($urandom_range(0, 150) == 0);
            if ($urandom_range(0, 999) == 0) begin
                #2 clr = 1'b1;
                #2 clr = 1'b0;
            end
        end

        @(negedge dclk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
